// File: rtl/id_stage.sv
// Decode / operand-fetch stage of the 64-bit RISC-V pipeline: register-file addressing,
// EX/MEM/WB bypass, load-use bubble insertion and the ID/EX pipeline register.
module id_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             ex_ready,
    input  logic             flush,
    input  logic [XLEN-1:0]  ex_fwd_data,
    input  logic [4:0]       mem_rd,
    input  logic             mem_wr,
    input  logic [XLEN-1:0]  mem_data,
    input  logic [4:0]       wb_rd,
    input  logic             wb_wr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rd,
    output logic             ex_wr,
    output logic             ex_is_load,
    output logic [31:0]      ex_instr,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;

    logic [6:0]       opcode_s;
    logic [4:0]       rd_s;
    logic [4:0]       rs1_s;
    logic [4:0]       rs2_s;
    logic             rs1_used_s;
    logic             rs2_used_s;
    logic             wr_s;
    logic             ex_fwd_ok_s;
    logic             load_use_s;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  op1_s;
    logic [XLEN-1:0]  op2_s;

    logic             ex_valid_r;
    logic [XLEN-1:0]  ex_pc_r;
    logic [XLEN-1:0]  ex_op1_r;
    logic [XLEN-1:0]  ex_op2_r;
    logic [XLEN-1:0]  ex_imm_r;
    logic [4:0]       ex_rd_r;
    logic             ex_wr_r;
    logic             ex_is_load_r;
    logic [31:0]      ex_instr_r;
    logic [CNT_W-1:0] stall_cnt_r;

    assign opcode_s = if_instr[6:0];
    assign rd_s     = if_instr[11:7];
    assign rs1_s    = if_instr[19:15];
    assign rs2_s    = if_instr[24:20];
    assign rs1      = rs1_s;
    assign rs2      = rs2_s;

    // A load still in EX has no data yet, so it can only be waited for, never forwarded.
    assign ex_fwd_ok_s = ex_valid_r & ex_wr_r & ~ex_is_load_r;

    // Source-use and write-enable decode.
    always_comb begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
        wr_s       = 1'b0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rs1_used_s = 1'b0;
                wr_s       = (rd_s != 5'd0);
            end
            OPC_OP: begin
                rs2_used_s = 1'b1;
                wr_s       = (rd_s != 5'd0);
            end
            OPC_STORE, OPC_BRANCH: begin
                rs2_used_s = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                wr_s       = (rd_s != 5'd0);
            end
            default: begin
                wr_s       = 1'b0;
            end
        endcase
    end

    // Immediate extraction by instruction format, sign-extended to XLEN.
    always_comb begin
        imm_s = {XLEN{1'b0}};
        case (opcode_s)
            OPC_STORE:
                imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OPC_BRANCH:
                imm_s = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_s = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'd0};
            OPC_JAL:
                imm_s = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
            OPC_OP, OPC_OP32:
                imm_s = {XLEN{1'b0}};
            default:
                imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
        endcase
    end

    // rs1 operand select: youngest producer wins, x0 is hardwired.
    always_comb begin
        op1_s = rs1_data;
        if (rs1_s == 5'd0) begin
            op1_s = {XLEN{1'b0}};
        end else if (ex_fwd_ok_s && (ex_rd_r == rs1_s)) begin
            op1_s = ex_fwd_data;
        end else if (mem_wr && (mem_rd == rs1_s)) begin
            op1_s = mem_data;
        end else if (wb_wr && (wb_rd == rs1_s)) begin
            op1_s = wb_data;
        end else begin
            op1_s = rs1_data;
        end
    end

    // rs2 operand select, same priority as rs1.
    always_comb begin
        op2_s = rs2_data;
        if (rs2_s == 5'd0) begin
            op2_s = {XLEN{1'b0}};
        end else if (ex_fwd_ok_s && (ex_rd_r == rs2_s)) begin
            op2_s = ex_fwd_data;
        end else if (mem_wr && (mem_rd == rs2_s)) begin
            op2_s = mem_data;
        end else if (wb_wr && (wb_rd == rs2_s)) begin
            op2_s = wb_data;
        end else begin
            op2_s = rs2_data;
        end
    end

    assign load_use_s = if_valid & ex_valid_r & ex_is_load_r & (ex_rd_r != 5'd0) &
                        ((rs1_used_s & (ex_rd_r == rs1_s)) | (rs2_used_s & (ex_rd_r == rs2_s)));

    // A flush discards the IF/ID entry, so it is always consumed even while EX is busy.
    assign id_ready = flush | (ex_ready & ~load_use_s);

    // ID/EX pipeline register and saturating load-use bubble counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid_r   <= 1'b0;
            ex_pc_r      <= {XLEN{1'b0}};
            ex_op1_r     <= {XLEN{1'b0}};
            ex_op2_r     <= {XLEN{1'b0}};
            ex_imm_r     <= {XLEN{1'b0}};
            ex_rd_r      <= 5'd0;
            ex_wr_r      <= 1'b0;
            ex_is_load_r <= 1'b0;
            ex_instr_r   <= 32'd0;
            stall_cnt_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            ex_valid_r   <= 1'b0;
        end else if (!ex_ready) begin
            ex_valid_r   <= ex_valid_r;
        end else if (load_use_s) begin
            ex_valid_r   <= 1'b0;
            if (stall_cnt_r != {CNT_W{1'b1}}) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end else begin
            ex_valid_r   <= if_valid;
            ex_pc_r      <= if_pc;
            ex_op1_r     <= op1_s;
            ex_op2_r     <= op2_s;
            ex_imm_r     <= imm_s;
            ex_rd_r      <= rd_s;
            ex_wr_r      <= wr_s;
            ex_is_load_r <= (opcode_s == OPC_LOAD);
            ex_instr_r   <= if_instr;
        end
    end

    assign ex_valid   = ex_valid_r;
    assign ex_pc      = ex_pc_r;
    assign ex_op1     = ex_op1_r;
    assign ex_op2     = ex_op2_r;
    assign ex_imm     = ex_imm_r;
    assign ex_rd      = ex_rd_r;
    assign ex_wr      = ex_wr_r;
    assign ex_is_load = ex_is_load_r;
    assign ex_instr   = ex_instr_r;
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected ID/EX contents are queued as each instruction
// is presented and compared one clock later.
module tb_id_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 16;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef struct packed {
        logic            v;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            wr;
        logic            ld;
        logic [31:0]     instr;
    } ex_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             if_valid = 1'b0;
    logic [31:0]      if_instr = 32'd0;
    logic [XLEN-1:0]  if_pc = 64'd0;
    logic             id_ready;
    logic [4:0]       rs1, rs2;
    logic [XLEN-1:0]  rs1_data = 64'd0, rs2_data = 64'd0;
    logic             ex_ready = 1'b1;
    logic             flush = 1'b0;
    logic [XLEN-1:0]  ex_fwd_data = 64'd0;
    logic [4:0]       mem_rd = 5'd0, wb_rd = 5'd0;
    logic             mem_wr = 1'b0, wb_wr = 1'b0;
    logic [XLEN-1:0]  mem_data = 64'd0, wb_data = 64'd0;
    logic             ex_valid, ex_wr, ex_is_load;
    logic [XLEN-1:0]  ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]       ex_rd;
    logic [31:0]      ex_instr;
    logic [CNT_W-1:0] stall_cnt;

    ex_t sb[$];
    ex_t cur, got, exp_e;
    int  errors = 0;
    int  checks = 0;

    id_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_ready(ex_ready), .flush(flush), .ex_fwd_data(ex_fwd_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_wr(wb_wr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_instr(ex_instr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs2f, input logic [4:0] rs1f,
                                          input logic [4:0] rdf, input logic [6:0] op);
        return {7'd0, rs2f, rs1f, 3'b000, rdf, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1f,
                                          input logic [2:0] f3, input logic [4:0] rdf,
                                          input logic [6:0] op);
        return {imm, rs1f, f3, rdf, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2f,
                                          input logic [4:0] rs1f, input logic [2:0] f3);
        return {imm[11:5], rs2f, rs1f, f3, imm[4:0], STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2f,
                                          input logic [4:0] rs1f);
        return {imm[12], imm[10:5], rs2f, rs1f, 3'b000, imm[4:1], imm[11], BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rdf);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rdf, JAL};
    endfunction

    function automatic ex_t mk(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] op1,
                               input logic [XLEN-1:0] op2, input logic [XLEN-1:0] imm,
                               input logic [4:0] rd, input logic wr, input logic ld,
                               input logic [31:0] instr);
        ex_t e;
        e.v = v; e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm;
        e.rd = rd; e.wr = wr; e.ld = ld; e.instr = instr;
        return e;
    endfunction

    function automatic ex_t sample();
        return mk(ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_wr, ex_is_load, ex_instr);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
        if_valid = 1'b1; if_instr = instr; if_pc = pc; rs1_data = d1; rs2_data = d2;
    endtask

    task automatic push(input ex_t e);
        sb.push_back(e);
        cur = e;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = sample(); checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_ex got=%h exp=0", got); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        rstn = 1'b1;
        cur = '0;
    endtask

    task automatic test_ex_bypass();
        logic [31:0] i_addi, i_add;
        i_addi = enc_i(12'd7, 5'd0, 3'b000, 5'd5, OPIMM);
        send(i_addi, 64'h100, 64'h11, 64'h22);
        #1; checks++;
        if ({id_ready, rs1, rs2} !== {1'b1, 5'd0, 5'd7}) begin
            errors++; $display("FAIL addi_comb got=%b/%0d/%0d exp=1/0/7", id_ready, rs1, rs2);
        end
        push(mk(1'b1, 64'h100, 64'h0, 64'h22, 64'h7, 5'd5, 1'b1, 1'b0, i_addi));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL addi_issue got=%h exp=%h", got, exp_e); end
        i_add = enc_r(5'd5, 5'd5, 5'd6, OP);
        ex_fwd_data = 64'h7;
        send(i_add, 64'h104, 64'h11, 64'h22);
        #1; checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL ex_byp_ready got=%b exp=1", id_ready); end
        push(mk(1'b1, 64'h104, 64'h7, 64'h7, 64'h0, 5'd6, 1'b1, 1'b0, i_add));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL ex_bypass got=%h exp=%h", got, exp_e); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL ex_byp_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_load_use();
        logic [31:0] i_ld, i_add;
        i_ld = enc_i(12'd0, 5'd1, 3'b011, 5'd7, LOAD);
        send(i_ld, 64'h200, 64'h1000, 64'h33);
        push(mk(1'b1, 64'h200, 64'h1000, 64'h0, 64'h0, 5'd7, 1'b1, 1'b1, i_ld));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL ld_issue got=%h exp=%h", got, exp_e); end
        i_add = enc_r(5'd2, 5'd7, 5'd8, OP);
        ex_fwd_data = 64'hBAD;
        send(i_add, 64'h204, 64'h99, 64'h44);
        #1; checks++;
        if ({id_ready, rs1, rs2} !== {1'b0, 5'd7, 5'd2}) begin
            errors++; $display("FAIL ld_use_comb got=%b/%0d/%0d exp=0/7/2", id_ready, rs1, rs2);
        end
        exp_e = cur; exp_e.v = 1'b0; push(exp_e);
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL ld_use_bubble got=%h exp=%h", got, exp_e); end
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL ld_use_cnt got=%0d exp=1", stall_cnt); end
        mem_wr = 1'b1; mem_rd = 5'd7; mem_data = 64'hDEAD;
        #1; checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL ld_use_release got=%b exp=1", id_ready); end
        push(mk(1'b1, 64'h204, 64'hDEAD, 64'h44, 64'h0, 5'd8, 1'b1, 1'b0, i_add));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL ld_use_mem_fwd got=%h exp=%h", got, exp_e); end
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL ld_use_cnt2 got=%0d exp=1", stall_cnt); end
        mem_wr = 1'b0;
    endtask

    task automatic test_wb_bypass();
        logic [31:0] i_addi;
        i_addi = enc_i(12'd1, 5'd3, 3'b000, 5'd9, OPIMM);
        wb_wr = 1'b1; wb_rd = 5'd3; wb_data = 64'h55;
        send(i_addi, 64'h300, 64'h11, 64'h22);
        push(mk(1'b1, 64'h300, 64'h55, 64'h22, 64'h1, 5'd9, 1'b1, 1'b0, i_addi));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL wb_bypass got=%h exp=%h", got, exp_e); end
        wb_wr = 1'b0;
    endtask

    task automatic test_priority();
        logic [31:0] i;
        i = enc_r(5'd0, 5'd0, 5'd10, OP);
        ex_fwd_data = 64'hFF;
        mem_wr = 1'b1; mem_rd = 5'd0; mem_data = 64'hFF;
        wb_wr = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
        send(i, 64'h400, 64'hFF, 64'hFF);
        push(mk(1'b1, 64'h400, 64'h0, 64'h0, 64'h0, 5'd10, 1'b1, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL x0_no_bypass got=%h exp=%h", got, exp_e); end
        mem_wr = 1'b0; wb_wr = 1'b0;
        i = enc_i(12'd1, 5'd0, 3'b000, 5'd4, OPIMM);
        send(i, 64'h404, 64'h11, 64'h22);
        push(mk(1'b1, 64'h404, 64'h0, 64'h22, 64'h1, 5'd4, 1'b1, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL addi_x4 got=%h exp=%h", got, exp_e); end
        i = enc_r(5'd4, 5'd4, 5'd11, OP);
        ex_fwd_data = 64'h1;
        mem_wr = 1'b1; mem_rd = 5'd4; mem_data = 64'h2;
        wb_wr = 1'b1; wb_rd = 5'd4; wb_data = 64'h3;
        send(i, 64'h408, 64'h11, 64'h22);
        push(mk(1'b1, 64'h408, 64'h1, 64'h1, 64'h0, 5'd11, 1'b1, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL ex_over_mem got=%h exp=%h", got, exp_e); end
        i = enc_r(5'd0, 5'd4, 5'd12, OP);
        send(i, 64'h40C, 64'h11, 64'h22);
        push(mk(1'b1, 64'h40C, 64'h2, 64'h0, 64'h0, 5'd12, 1'b1, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL mem_over_wb got=%h exp=%h", got, exp_e); end
        mem_wr = 1'b0; wb_wr = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] i_ld, i;
        i_ld = enc_i(12'd8, 5'd2, 3'b011, 5'd13, LOAD);
        send(i_ld, 64'h500, 64'h70, 64'h80);
        push(mk(1'b1, 64'h500, 64'h70, 64'h80, 64'h8, 5'd13, 1'b1, 1'b1, i_ld));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL flush_ld got=%h exp=%h", got, exp_e); end
        i = enc_r(5'd13, 5'd13, 5'd14, OP);
        send(i, 64'h504, 64'h11, 64'h22);
        flush = 1'b1;
        #1; checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", id_ready); end
        exp_e = cur; exp_e.v = 1'b0; push(exp_e);
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL flush_bubble got=%h exp=%h", got, exp_e); end
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=1", stall_cnt); end
        flush = 1'b0;
    endtask

    task automatic test_hold();
        logic [31:0] i, i2;
        i = enc_i(12'd5, 5'd0, 3'b000, 5'd15, OPIMM);
        send(i, 64'h600, 64'h11, 64'h22);
        push(mk(1'b1, 64'h600, 64'h0, 64'h22, 64'h5, 5'd15, 1'b1, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL hold_pre got=%h exp=%h", got, exp_e); end
        i2 = enc_r(5'd15, 5'd15, 5'd16, OP);
        ex_fwd_data = 64'h5;
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(i2, 64'h604, 64'h100 + 64'(k), 64'h200 + 64'(k));
            #1; checks++;
            if (id_ready !== 1'b0) begin errors++; $display("FAIL hold_ready c%0d got=%b exp=0", k, id_ready); end
            push(cur);
            tick; got = sample(); exp_e = sb.pop_front(); checks++;
            if (got !== exp_e) begin errors++; $display("FAIL hold_stable c%0d got=%h exp=%h", k, got, exp_e); end
        end
        ex_ready = 1'b1;
        send(i2, 64'h604, 64'h11, 64'h22);
        push(mk(1'b1, 64'h604, 64'h5, 64'h5, 64'h0, 5'd16, 1'b1, 1'b0, i2));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL hold_release got=%h exp=%h", got, exp_e); end
    endtask

    task automatic test_imm();
        logic [31:0] i;
        i = enc_s(12'hFF8, 5'd2, 5'd1, 3'b011);
        send(i, 64'h700, 64'hA1, 64'hB2);
        push(mk(1'b1, 64'h700, 64'hA1, 64'hB2, 64'hFFFF_FFFF_FFFF_FFF8, 5'd24, 1'b0, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL imm_s got=%h exp=%h", got, exp_e); end
        i = enc_b(13'h1FFC, 5'd2, 5'd1);
        send(i, 64'h704, 64'hA1, 64'hB2);
        push(mk(1'b1, 64'h704, 64'hA1, 64'hB2, 64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 1'b0, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL imm_b got=%h exp=%h", got, exp_e); end
        i = {20'h80000, 5'd5, LUI};
        send(i, 64'h708, 64'hA1, 64'hB2);
        push(mk(1'b1, 64'h708, 64'h0, 64'h0, 64'hFFFF_FFFF_8000_0000, 5'd5, 1'b1, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL imm_u got=%h exp=%h", got, exp_e); end
        i = enc_j(21'h000800, 5'd1);
        send(i, 64'h70C, 64'hA1, 64'hB2);
        push(mk(1'b1, 64'h70C, 64'h0, 64'hB2, 64'h800, 5'd1, 1'b1, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL imm_j got=%h exp=%h", got, exp_e); end
        i = enc_j(21'h100000, 5'd0);
        send(i, 64'h710, 64'hA1, 64'hB2);
        push(mk(1'b1, 64'h710, 64'h0, 64'h0, 64'hFFFF_FFFF_FFF0_0000, 5'd0, 1'b0, 1'b0, i));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL imm_j_min got=%h exp=%h", got, exp_e); end
        if_valid = 1'b0;
        exp_e = cur; exp_e.v = 1'b0; push(exp_e);
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL idle_slot got=%h exp=%h", got, exp_e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] i_ld, i_add;
        i_ld = enc_i(12'd0, 5'd1, 3'b011, 5'd7, LOAD);
        send(i_ld, 64'h800, 64'h10, 64'h20);
        push(mk(1'b1, 64'h800, 64'h10, 64'h0, 64'h0, 5'd7, 1'b1, 1'b1, i_ld));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL rst_mid_ld got=%h exp=%h", got, exp_e); end
        i_add = enc_r(5'd2, 5'd7, 5'd8, OP);
        send(i_add, 64'h804, 64'h10, 64'h20);
        #1; checks++;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%b exp=0", id_ready); end
        rstn = 1'b0;
        #1; got = sample(); checks++;
        if (got !== '0) begin errors++; $display("FAIL rst_mid_ex got=%h exp=0", got); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt got=%0d exp=0", stall_cnt); end
        tick; got = sample(); checks++;
        if (got !== '0) begin errors++; $display("FAIL rst_mid_hold got=%h exp=0", got); end
        rstn = 1'b1;
        cur = '0;
        #1; checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b exp=1", id_ready); end
        push(mk(1'b1, 64'h804, 64'h10, 64'h20, 64'h0, 5'd8, 1'b1, 1'b0, i_add));
        tick; got = sample(); exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL post_rst_issue got=%h exp=%h", got, exp_e); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL post_rst_cnt got=%0d exp=0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_ex_bypass();
        test_load_use();
        test_wb_bypass();
        test_priority();
        test_flush();
        test_hold();
        test_imm();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
